// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between IF and MEM,
// serialising 1/2/4-byte accesses into byte transfers (MEM first).
// Ports: clk_in, rst_in (async, active-low), rdy_in (global freeze);
//   IF: if_req/if_addr -> if_done/if_inst, if_stall;
//   MEM: mem_req/mem_we/mem_addr/mem_len/mem_wdata -> mem_done/
//        mem_rdata, mem_stall;
//   RAM: ram_a/ram_dout/ram_wr out, ram_din in (one-cycle latency).
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        if_stall,
    output logic        mem_stall,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic        ram_wr
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_own_mem;
    logic [2:0]  r_cnt;
    logic [2:0]  r_len;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic        r_wr;
    logic [31:0] w_buf_nxt;
    logic [2:0]  w_len_req;
    logic        w_gnt_mem;
    logic        w_gnt_if;
    logic        w_abort;
    logic        w_rd_last;
    logic        w_wr_last;

    assign if_stall  = if_req & ~if_done;
    assign mem_stall = mem_req & ~mem_done;
    assign ram_wr    = r_wr & rdy_in;

    assign w_len_req = (mem_len == 2'b00) ? 3'd1 :
                       (mem_len == 2'b01) ? 3'd2 : 3'd4;

    // In a read, r_cnt = j means ram_din holds byte j-1 this cycle.
    always_comb begin
        w_buf_nxt = r_buf;
        case (r_cnt)
            3'd1:    w_buf_nxt[7:0]   = ram_din;
            3'd2:    w_buf_nxt[15:8]  = ram_din;
            3'd3:    w_buf_nxt[23:16] = ram_din;
            3'd4:    w_buf_nxt[31:24] = ram_din;
            default: ;
        endcase
    end

    // Requests are masked during their own done pulse so a held
    // request is not granted a second time.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_mem   = 1'b0;
        w_gnt_if    = 1'b0;
        w_abort     = 1'b0;
        w_rd_last   = 1'b0;
        w_wr_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_stall) begin
                    w_gnt_mem   = 1'b1;
                    w_state_nxt = mem_we ? S_WR : S_RD;
                end else if (if_stall) begin
                    w_gnt_if    = 1'b1;
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                if (!r_own_mem && !if_req) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == r_len) begin
                    w_rd_last   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR: begin
                if (r_cnt == r_len - 3'd1) begin
                    w_wr_last   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_own_mem <= 1'b0;
            r_cnt     <= 3'd0;
            r_len     <= 3'd0;
            r_wdata   <= 32'd0;
            r_buf     <= 32'd0;
            r_wr      <= 1'b0;
            ram_a     <= 32'd0;
            ram_dout  <= 8'd0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_inst   <= 32'd0;
            mem_rdata <= 32'd0;
        end else if (rdy_in) begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            if (w_gnt_mem || w_gnt_if) begin
                r_own_mem <= w_gnt_mem;
                r_cnt     <= 3'd0;
                r_len     <= w_gnt_mem ? w_len_req : 3'd4;
                r_buf     <= 32'd0;
                r_wdata   <= mem_wdata;
                ram_dout  <= mem_wdata[7:0];
                ram_a     <= w_gnt_mem ? mem_addr : if_addr;
                r_wr      <= w_gnt_mem & mem_we;
            end else if (r_state == S_RD && !w_abort) begin
                r_buf <= w_buf_nxt;
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt + 3'd1 < r_len) begin
                    ram_a <= ram_a + 32'd1;
                end
                if (w_rd_last) begin
                    if (r_own_mem) begin
                        mem_done  <= 1'b1;
                        mem_rdata <= w_buf_nxt;
                    end else begin
                        if_done <= 1'b1;
                        if_inst <= w_buf_nxt;
                    end
                end
            end else if (r_state == S_WR) begin
                if (w_wr_last) begin
                    r_wr     <= 1'b0;
                    mem_done <= 1'b1;
                end else begin
                    r_cnt    <= r_cnt + 3'd1;
                    ram_a    <= ram_a + 32'd1;
                    ram_dout <= r_wdata[15:8];
                    r_wdata  <= r_wdata >> 8;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized checks of mem_arbiter
// against a transaction-level model with absolute cycle timing.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [1:0]  mem_len = 2'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        if_stall;
    logic        mem_stall;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'd0;
    logic        ram_wr;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_len(mem_len), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .if_stall(if_stall), .mem_stall(mem_stall),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din),
        .ram_wr(ram_wr)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            32'h030: return 8'h80;
            default: return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    // RAM: addresses alias on the low 16 bits; unwritten bytes read
    // their init value.
    logic [7:0] ram   [0:65535];
    bit         ram_v [0:65535];
    logic [7:0] ref_mem [0:65535];
    bit         ref_v   [0:65535];

    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (ram_wr) begin
                ram[ram_a[15:0]]   <= ram_dout;
                ram_v[ram_a[15:0]] <= 1'b1;
            end
            ram_din <= ram_v[ram_a[15:0]] ? ram[ram_a[15:0]]
                                          : init_byte(ram_a);
        end
    end

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_v[a[15:0]] ? ram[a[15:0]] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_v[a[15:0]] ? ref_mem[a[15:0]] : init_byte(a);
    endfunction

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: current access plus its grant point in ready-cycle time.
    int          rc = 0;
    int          m_g = 0;
    int          m_n = 0;
    bit          m_busy = 0;
    bit          m_mem = 0;
    bit          m_we = 0;
    logic [31:0] m_base = 0;
    logic [31:0] m_wdata = 0;
    bit          e_if_done = 0;
    bit          e_mem_done = 0;
    logic [31:0] e_if_inst = 0;
    logic [31:0] e_mem_rdata = 0;
    bit          mem_fin = 0;
    bit          if_fin = 0;
    bit          ifd_seen = 0;

    task automatic model_reset();
        m_busy      = 0;
        e_if_done   = 0;
        e_mem_done  = 0;
        e_if_inst   = 0;
        e_mem_rdata = 0;
        mem_fin     = 0;
        if_fin      = 0;
    endtask

    task automatic check_outputs();
        int   k;
        logic ew;
        k  = rc - m_g;
        ew = 1'b0;
        if (m_busy && m_we && k < m_n) ew = rdy_in;
        chk("ram_wr", 32'(ram_wr), 32'(ew));
        if (m_busy && k < m_n)
            chk("ram_a", ram_a, m_base + 32'(k));
        if (m_busy && m_we && k < m_n)
            chk("ram_dout", 32'(ram_dout),
                (m_wdata >> (8 * k)) & 32'hFF);
        chk("if_done", 32'(if_done), 32'(e_if_done));
        chk("mem_done", 32'(mem_done), 32'(e_mem_done));
        chk("if_inst", if_inst, e_if_inst);
        chk("mem_rdata", mem_rdata, e_mem_rdata);
        chk("if_stall", 32'(if_stall), 32'(if_req & ~e_if_done));
        chk("mem_stall", 32'(mem_stall), 32'(mem_req & ~e_mem_done));
    endtask

    task automatic model_edge();
        int          k;
        logic [31:0] w;
        bit          nd_if;
        bit          nd_mem;
        if (!rst_in) begin
            model_reset();
            return;
        end
        if (!rdy_in) return;
        if (e_mem_done) mem_fin = 1;
        if (e_if_done) if_fin = 1;
        nd_if  = 0;
        nd_mem = 0;
        k = rc - m_g;
        if (m_busy && !m_we) begin
            if (!m_mem && !if_req) begin
                m_busy = 0;
            end else if (k == m_n) begin
                w = 32'd0;
                for (int i = 0; i < m_n; i++)
                    w |= 32'(ref_rd(m_base + 32'(i))) << (8 * i);
                m_busy = 0;
                if (m_mem) begin
                    nd_mem = 1;
                    e_mem_rdata = w;
                end else begin
                    nd_if = 1;
                    e_if_inst = w;
                end
            end
        end else if (m_busy) begin
            w = m_base + 32'(k);
            ref_mem[w[15:0]] = 8'(m_wdata >> (8 * k));
            ref_v[w[15:0]]   = 1'b1;
            if (k == m_n - 1) begin
                m_busy = 0;
                nd_mem = 1;
            end
        end else if (mem_req && !e_mem_done) begin
            m_busy  = 1;
            m_mem   = 1;
            m_we    = mem_we;
            m_base  = mem_addr;
            m_wdata = mem_wdata;
            m_n     = (mem_len == 2'd0) ? 1 : (mem_len == 2'd1) ? 2 : 4;
            m_g     = rc + 1;
        end else if (if_req && !e_if_done) begin
            m_busy = 1;
            m_mem  = 0;
            m_we   = 0;
            m_base = if_addr;
            m_n    = 4;
            m_g    = rc + 1;
        end
        e_if_done  = nd_if;
        e_mem_done = nd_mem;
        rc++;
    endtask

    task automatic cycle();
        @(negedge clk_in);
        check_outputs();
        model_edge();
        @(posedge clk_in);
        #1;
        ifd_seen |= if_done;
    endtask

    task automatic wait_done(input bit is_mem, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(is_mem ? mem_done : if_done) && n < 30);
    endtask

    function automatic logic [31:0] raddr();
        if ($urandom_range(0, 3) == 0)
            return 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        return 32'($urandom_range(0, 63));
    endfunction

    initial begin
        int n;
        #1 rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_mem_done", 32'(mem_done), 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        model_reset();
        rst_in = 1'b1;
        cycle();

        // IF fetch of 0x100
        if_req = 1'b1;
        if_addr = 32'h100;
        wait_done(1'b0, n);
        chk("if_latency", n, 6);
        chk("if_word", if_inst, 32'h00100513);
        cycle();
        if_req = 1'b0;
        cycle();

        // 2-byte store at 0x2000
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_len = 2'b01;
        mem_addr = 32'h2000;
        mem_wdata = 32'hDEADBEEF;
        wait_done(1'b1, n);
        chk("st_latency", n, 3);
        cycle();
        mem_req = 1'b0;
        chk("st_2000", 32'(ram_rd(32'h2000)), 32'hEF);
        chk("st_2001", 32'(ram_rd(32'h2001)), 32'hBE);
        chk("st_2002", 32'(ram_rd(32'h2002)), 32'(init_byte(32'h2002)));
        cycle();

        // simultaneous requests: MEM load first, then IF
        if_req = 1'b1;
        if_addr = 32'h100;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_len = 2'b00;
        mem_addr = 32'h30;
        wait_done(1'b1, n);
        chk("ld_latency", n, 3);
        chk("ld_data", mem_rdata, 32'h00000080);
        cycle();
        mem_req = 1'b0;
        chk("if_after_mem", ram_a, 32'h100);
        wait_done(1'b0, n);
        chk("if2_latency", n, 5);
        cycle();
        if_req = 1'b0;
        cycle();

        // IF abort in G+2, then an immediate MEM grant
        if_req = 1'b1;
        if_addr = 32'h104;
        cycle();
        cycle();
        cycle();
        if_req = 1'b0;
        ifd_seen = 1'b0;
        cycle();
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_len = 2'b10;
        mem_addr = 32'h100;
        cycle();
        chk("mem_after_abort", ram_a, 32'h100);
        wait_done(1'b1, n);
        chk("ld4_latency", n, 5);
        chk("ld4_data", mem_rdata, 32'h00100513);
        chk("no_if_done", 32'(ifd_seen), 32'd0);
        cycle();
        mem_req = 1'b0;
        cycle();

        // 4-byte store across the wrap with a 3-cycle freeze at G+1
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_len = 2'b10;
        mem_addr = 32'hFFFFFFFE;
        mem_wdata = 32'h44332211;
        cycle();
        cycle();
        rdy_in = 1'b0;
        cycle();
        cycle();
        cycle();
        rdy_in = 1'b1;
        wait_done(1'b1, n);
        chk("frz_latency", n + 5, 8);
        cycle();
        mem_req = 1'b0;
        chk("wrap_fffe", 32'(ram_rd(32'hFFFFFFFE)), 32'h11);
        chk("wrap_ffff", 32'(ram_rd(32'hFFFFFFFF)), 32'h22);
        chk("wrap_0000", 32'(ram_rd(32'h0)), 32'h33);
        chk("wrap_0001", 32'(ram_rd(32'h1)), 32'h44);
        cycle();

        // reset in the middle of a 4-byte store at 0x40
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_len = 2'b10;
        mem_addr = 32'h40;
        mem_wdata = 32'hA1B2C3D4;
        cycle();
        cycle();
        #2 rst_in = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("mrst_ram_a", ram_a, 32'd0);
        chk("mrst_ram_dout", 32'(ram_dout), 32'd0);
        chk("mrst_ram_wr", 32'(ram_wr), 32'd0);
        chk("mrst_mem_done", 32'(mem_done), 32'd0);
        chk("mrst_if_inst", if_inst, 32'd0);
        chk("mrst_mem_rdata", mem_rdata, 32'd0);
        model_reset();
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("wr_after_rst", 32'(ram_wr), 32'd0);
        end
        chk("mrst_0040", 32'(ram_rd(32'h40)), 32'hD4);
        chk("mrst_0041", 32'(ram_rd(32'h41)), 32'(init_byte(32'h41)));

        // randomized traffic
        mem_fin = 0;
        if_fin = 0;
        for (int c = 0; c < 4000; c++) begin
            rdy_in = ($urandom_range(0, 7) != 0);
            if (mem_fin || !mem_req) begin
                mem_fin = 0;
                if ($urandom_range(0, 3) == 0) begin
                    mem_req = 1'b1;
                    mem_we = 1'($urandom_range(0, 1));
                    mem_len = 2'($urandom_range(0, 3));
                    mem_addr = raddr();
                    mem_wdata = $urandom;
                end else begin
                    mem_req = 1'b0;
                end
            end
            if (if_fin || !if_req) begin
                if_fin = 0;
                if ($urandom_range(0, 2) == 0) begin
                    if_req = 1'b1;
                    if_addr = raddr();
                end else begin
                    if_req = 1'b0;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage, and serialises each 1/2/4-byte access into byte transfers. It sits between the pipeline and the RAM. It drives the stall signals that freeze the pipeline registers (the `busy_in` inputs of the inter-stage registers) while an access is outstanding. MEM accesses are always granted ahead of IF accesses.

## Interface
Parameters: none.
- clk_in  in  1  clock; all state updates on rising edge
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global ready; low freezes all state
- if_req  in  1  IF requests a 4-byte instruction read; held until if_done or withdrawn
- if_addr  in  32  IF byte address
- if_done  out  1  one-cycle pulse: if_inst valid
- if_inst  out  32  fetched word, little-endian
- mem_req  in  1  MEM stage requests an access; held until mem_done
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  32  MEM byte address
- mem_len  in  2  access size: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes (11 is treated as 4 bytes)
- mem_wdata  in  32  write data; the low bytes are used
- mem_done  out  1  one-cycle pulse: access complete; mem_rdata valid for reads
- mem_rdata  out  32  read data, zero-extended
- if_stall  out  1  if_req & ~if_done (combinational)
- mem_stall  out  1  mem_req & ~mem_done (combinational); feeds the pipeline-register busy inputs
- ram_a  out  32  RAM byte address
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; valid one cycle after its address is presented
- ram_wr  out  1  RAM write strobe; the driven value is the registered strobe ANDed with rdy_in

## Operation
- States:
  - IDLE: no access in progress.
  - RD: read in progress; tracks the owner (IF or MEM).
  - WR: write in progress.
  - Byte counter cnt[2:0] and length n ∈ {1,2,4} are latched at grant.
- Arbitration in IDLE (on a ready edge):
  - mem_req has priority; it goes to WR if mem_we is set, otherwise to RD with owner MEM.
  - Otherwise, if if_req is set, go to RD with owner IF and n = 4.
  - Otherwise stay in IDLE.
- Base address and write data are latched at grant. Request inputs are ignored until the access completes.
- Address of byte k is base + k, computed with 32-bit wrap-around (0xFFFFFFFF + 1 = 0x00000000).
- Byte k occupies bits [8k+7:8k] of the result word. Unread upper bytes are 0.
- Write: byte k of the latched write data is driven on ram_dout with ram_wr = 1.
- IF abort: if if_req is low in any RD/IF cycle, the access is dropped and the state returns to IDLE at the next edge. No if_done is produced; partial data is discarded.
- MEM accesses are never aborted. A write always completes all n bytes.
- rdy_in low: state, counters, outputs and done pulses all hold, and ram_wr is forced to 0. The RAM honours rdy_in identically, so ram_din stays aligned.
- Reset (rst_in low, asynchronous):
  - State goes to IDLE.
  - ram_a = 0, ram_dout = 0, ram_wr = 0.
  - if_done = 0, mem_done = 0, if_inst = 0, mem_rdata = 0, cnt = 0.
  - Reset mid-access abandons the access; the RAM sees no further writes.

## Timing
- Let G be the first cycle after the grant edge. All cycle counts assume rdy_in stays high.
- Read of n bytes:
  - ram_a = base + k in cycle G+k, for k = 0..n-1.
  - Byte k is captured from ram_din at the end of cycle G+k+1.
  - done is high and data valid in cycle G+n+1.
  - State is IDLE in that done cycle, so the next grant can occur at the edge ending it.
  - A 4-byte fetch occupies 6 cycles from request to done.
- Write of n bytes:
  - ram_wr = 1, ram_a = base + k, ram_dout = byte k in cycle G+k.
  - done is high in cycle G+n; ram_wr = 0 in that cycle.
- Done pulses last exactly one cycle. if_inst and mem_rdata hold their value until the next completed read by the same owner.
- ram_a, ram_dout and the pre-gating ram_wr are registered outputs.
- Simultaneous if_req and mem_req in IDLE: MEM is granted. IF waits, and is granted in the cycle after mem_done if still requested.
- A request that arrives during another access is not acknowledged. Its stall output stays high until its own done.

## Test plan
- IF only, if_addr = 0x100, RAM bytes 0x13,0x05,0x10,0x00:
  - ram_a = 0x100..0x103 in cycles G..G+3.
  - if_done in G+5 with if_inst = 0x00100513.
  - if_stall low only in that cycle.
- MEM store, mem_len = 01, mem_addr = 0x2000, mem_wdata = 0xDEADBEEF:
  - ram_wr = 1 with (0x2000, 0xEF) in G and (0x2001, 0xBE) in G+1.
  - No write to 0x2002.
  - mem_done in G+2.
- if_req and mem_req (1-byte load, mem_addr = 0x30, RAM holds 0x80) rise together:
  - mem_done with mem_rdata = 0x00000080 first.
  - IF then granted; ram_a = if_addr in the cycle after mem_done.
- IF abort: drop if_req in cycle G+2 of a fetch:
  - No if_done is produced.
  - State is IDLE next cycle.
  - A subsequent mem_req is granted immediately.
- rdy_in low for 3 cycles during G+1 of a 4-byte store at 0xFFFFFFFE:
  - ram_wr = 0 while rdy_in is low.
  - Bytes go to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 in order, with no repeated or skipped byte.
  - mem_done is 3 cycles later than nominal.
- rst_in pulsed low mid-write:
  - All outputs go to 0 immediately.
  - State returns to IDLE; no ram_wr after reset is released until a new grant.
